// File: rtl/fetch_unit_if.sv
// Program-memory write port of the fetch stage: valid/ready handshake carrying address and data.
// Latency: none (wires only). Backpressure: slave holds ready low while it is executing; master keeps valid asserted.
interface fetch_unit_if #(
    parameter int PC_W = 4,
    parameter int OP_W = 8
);
    logic            prog_valid;
    logic            prog_ready;
    logic [PC_W-1:0] prog_addr;
    logic [OP_W-1:0] prog_data;

    modport master (
        output prog_valid,
        output prog_addr,
        output prog_data,
        input  prog_ready
    );

    modport slave (
        input  prog_valid,
        input  prog_addr,
        input  prog_data,
        output prog_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// TD4 fetch stage: program memory, PC, icount and HALT/RUN/STEP control; FETCH_BOOT_ROM_EN selects the demo reset image.
// Latency: op = mem[pc] combinationally (0 cycles); a retire updates pc on the next edge.
// Backpressure: prog_ready is high only in HALT, so writes stall while the core executes.
module fetch_unit #(
    parameter int PC_W = 4,
    parameter int OP_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            step,
    input  logic            pc_load_n,
    input  logic [PC_W-1:0] pc_target,
    fetch_unit_if.slave     prog,
    output logic [OP_W-1:0] op,
    output logic            op_valid,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      icount,
    output logic            halted
);
    localparam int DEPTH = 1 << PC_W;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [PC_W-1:0]              pc_q, pc_d;
    logic [7:0]                   icount_q, icount_d;
    logic [DEPTH-1:0][OP_W-1:0]   mem_q, mem_d;
    logic                         wr_en;

    function automatic logic [DEPTH-1:0][OP_W-1:0] mem_reset_image();
        logic [DEPTH-1:0][OP_W-1:0] img;
        img = '0;
`ifdef FETCH_BOOT_ROM_EN
        // OUT 1, OUT 2, OUT 4, OUT 8, JMP 0
        img[0] = OP_W'(8'hB1);
        img[1] = OP_W'(8'hB2);
        img[2] = OP_W'(8'hB4);
        img[3] = OP_W'(8'hB8);
        img[4] = OP_W'(8'hF0);
`endif
        return img;
    endfunction

    always_comb begin
        state_d  = state_q;
        op_valid = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_HALT: begin
                halted = 1'b1;
                if (run)       state_d = S_RUN;
                else if (step) state_d = S_STEP;
            end
            S_RUN: begin
                op_valid = 1'b1;
                if (!run) state_d = S_HALT;
            end
            S_STEP: begin
                op_valid = 1'b1;
                state_d  = S_HALT;
            end
            default: state_d = S_HALT;
        endcase
    end

    assign prog.prog_ready = halted;
    assign wr_en           = prog.prog_valid & halted;

    always_comb begin
        pc_d     = pc_q;
        icount_d = icount_q;
        if (op_valid) begin
            pc_d     = pc_load_n ? pc_q + PC_W'(1) : pc_target;
            icount_d = icount_q + 8'd1;
        end
    end

    // Writing in HALT never races a fetch, so op simply reflects the new byte next cycle.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[prog.prog_addr] = prog.prog_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HALT;
            pc_q     <= '0;
            icount_q <= '0;
            mem_q    <= mem_reset_image();
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            icount_q <= icount_d;
            mem_q    <= mem_d;
        end
    end

    assign op     = mem_q[pc_q];
    assign pc     = pc_q;
    assign icount = icount_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the TD4 core: holds the 16 x 8-bit program memory and the program counter, and presents the current instruction byte `op` to the instruction decoder. Run/halt/single-step control is owned here. The memory is writable through a valid/ready port while halted. The PC is redirected by the active-low PC load strobe and the target value returned from the execute side.

## Interface
Parameters:
- `PC_W`, 4, program counter width; memory depth is 2**PC_W
- `OP_W`, 8, instruction width ({opcode[7:4], im[3:0]})

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  level; 1 = free-run execution
- `step`  in  1  single-cycle pulse; execute one instruction while halted
- `pc_load_n`  in  1  active-low PC load (decoder load[3]); 0 = jump taken
- `pc_target`  in  PC_W  jump target (ALU result)
- `prog_valid`  in  1  program write request
- `prog_ready`  out  1  program write accepted when valid&ready
- `prog_addr`  in  PC_W  program write address
- `prog_data`  in  OP_W  program write data
- `op`  out  OP_W  instruction byte to decoder, = mem[pc]
- `op_valid`  out  1  op is being executed this cycle
- `pc`  out  PC_W  current program counter
- `icount`  out  8  retired-instruction counter
- `halted`  out  1  1 when in HALT state

## Operation
- States: HALT, RUN, STEP.
- HALT:
  - op_valid=0, halted=1, prog_ready=1.
  - run=1 -> RUN; else step=1 -> STEP; run has priority when both are high.
- RUN:
  - op_valid=1 every cycle.
  - run=0 sampled at an edge -> HALT. The instruction presented in that cycle still retires.
- STEP:
  - op_valid=1 for exactly one cycle, then -> HALT unconditionally.
  - step held high yields one instruction every two cycles.
- Retire, on each edge with op_valid=1:
  - pc <= pc_load_n ? pc+1 : pc_target.
  - pc+1 wraps 15 -> 0; no overflow flag.
  - icount <= icount+1, wraps 255 -> 0.
- With op_valid=0, pc, icount, pc_load_n and pc_target are ignored; pc holds.
- op = mem[pc], combinational read. It is stable in HALT, so the decoder may observe it.
- Program write:
  - prog_ready = halted.
  - On an edge with prog_valid & prog_ready, mem[prog_addr] <= prog_data. One write per cycle.
  - In RUN/STEP prog_ready=0, and the requester must hold valid until accepted.
  - A write to mem[pc] is reflected on op the next cycle.
- Write and leave-HALT in the same cycle: the write completes. The first executed op is the new data if the address equals pc.

## Timing
- Reset values (async assert, sync to clk at deassert): state=HALT, pc=0, icount=0, op_valid=0, halted=1, prog_ready=1, mem per Configuration.
- Reset mid-operation: state, pc and icount clear immediately. An in-flight program write is dropped and memory is re-initialised.
- Fetch latency 0: op is valid in the same cycle pc changes.
- Jump latency 1: the target is on pc the cycle after the retiring edge.
- RUN throughput: 1 instruction/cycle.
- HALT -> RUN: the first op_valid is the cycle after run is sampled high.

## Configuration
- `FETCH_BOOT_ROM_EN` defined: reset loads the demo program.
  - mem[0..4] = 0xB1, 0xB2, 0xB4, 0xB8, 0xF0 (OUT 1, OUT 2, OUT 4, OUT 8, JMP 0).
  - All remaining locations = 0x00.
- Not defined: all locations reset to 0x00 (ADD A,0).
- Program-write behaviour is identical in both builds.

## Test plan
- Reset with FETCH_BOOT_ROM_EN:
  - Stimulus: raise run, keep pc_load_n=1 except when op=0xF0, where pc_load_n=0 and pc_target=0.
  - Required: pc sequence 0,1,2,3,4,0,1; op 0xB1,0xB2,0xB4,0xB8,0xF0,0xB1; icount=6.
- Halted write:
  - Stimulus: write addr 5 data 0x3A, then pulse step 6 times with pc_load_n=1.
  - Required: pc ends at 6; op was 0x3A when pc=5; each step gives exactly one op_valid cycle.
- Wrap:
  - Stimulus: in RUN with pc_load_n=1, run 16 cycles from pc=0.
  - Required: pc returns to 0; icount=16.
- Write during RUN:
  - Stimulus: assert prog_valid with addr 2 data 0x77.
  - Required: prog_ready=0 until run drops and HALT is entered; then the write is accepted and mem[2]=0x77.
- Async reset asserted mid-RUN at pc=3 with a pending write:
  - Required: pc=0, icount=0, halted=1 immediately; mem[2] holds its reset value (0x00 without the macro); no write occurs.
